// File: rtl/carpark_event_logger.sv
// Write-side front end for the car-park record RAM: buffers events and appends them as a circular log.
// Build option LOGGER_TIMESTAMP_EN: stamp field carries the tick counter instead of an acceptance sequence number.
module carpark_event_logger #(
    parameter int DEPTH      = 128,
    parameter int ADDR_W     = 7,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              TickEn,
    input  logic              EventValid,
    output logic              EventReady,
    input  logic [2:0]        EventType,
    input  logic [6:0]        SlotId,
    input  logic              BusyWR,
    output logic              WrEnable,
    output logic [39:0]       WrData,
    output logic [ADDR_W-1:0] AddressWR,
    output logic [ADDR_W:0]   Count,
    output logic              Wrapped,
    output logic              Idle
);
    localparam int FIDX_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_t;

    state_t            state, state_n;
    logic [39:0]       fifo_mem [FIFO_DEPTH];
    logic [FIDX_W-1:0] fifo_wr, fifo_rd;
    logic [FIDX_W:0]   fifo_count;
    logic [ADDR_W-1:0] wr_ptr;
    logic [29:0]       stamp;
    logic              push, pop, fifo_empty;

    assign EventReady = (fifo_count < (FIDX_W+1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign push       = EventValid && EventReady;
    assign pop        = (state == S_ISSUE);
    assign Idle       = fifo_empty && (state == S_IDLE);

`ifdef LOGGER_TIMESTAMP_EN
    always_ff @(posedge Clock) begin
        if (!Reset)
            stamp <= '0;
        else if (TickEn)
            stamp <= stamp + 30'd1;
    end
`else
    logic unused_tick;
    assign unused_tick = TickEn;

    always_ff @(posedge Clock) begin
        if (!Reset)
            stamp <= '0;
        else if (push)
            stamp <= stamp + 30'd1;
    end
`endif

    // Records are packed at acceptance so the stamp reflects the pre-tick value.
    always_ff @(posedge Clock) begin
        if (push)
            fifo_mem[fifo_wr] <= {EventType, SlotId, stamp};
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            fifo_wr    <= '0;
            fifo_rd    <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                fifo_wr <= fifo_wr + FIDX_W'(1);
            if (pop)
                fifo_rd <= fifo_rd + FIDX_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (FIDX_W+1)'(1);
                2'b01:   fifo_count <= fifo_count - (FIDX_W+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (!fifo_empty && !BusyWR) state_n = S_ISSUE;
            S_ISSUE: state_n = S_HOLD;
            S_HOLD:  state_n = (!fifo_empty && !BusyWR) ? S_ISSUE : S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Strobe, data and address are loaded on entry to ISSUE so they are registered outputs.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state     <= S_IDLE;
            WrEnable  <= 1'b0;
            WrData    <= '0;
            AddressWR <= '0;
            wr_ptr    <= '0;
            Count     <= '0;
            Wrapped   <= 1'b0;
        end else begin
            state    <= state_n;
            WrEnable <= (state_n == S_ISSUE);
            if (state_n == S_ISSUE) begin
                WrData    <= fifo_mem[fifo_rd];
                AddressWR <= wr_ptr;
            end
            if (state == S_ISSUE) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
                if (wr_ptr == ADDR_W'(DEPTH - 1))
                    Wrapped <= 1'b1;
                if (Count != (ADDR_W+1)'(DEPTH))
                    Count <= Count + (ADDR_W+1)'(1);
            end
        end
    end
endmodule
